// File: rtl/gmii_pkg.sv
// gmii_pkg: types and constants shared by the GMII transmit path and the
// receive-side checker.
//   tx_state_e      : transmitter FSM states
//   PREAMBLE_BYTE   : 0x55 preamble byte
//   SFD_BYTE        : 0xD5 start-of-frame delimiter
//   CRC_INIT        : CRC-32 register seed
//   CRC_POLY        : reflected CRC-32 polynomial
//   CRC_RESIDUE     : register value after a frame plus its own FCS
//   BYTE_CNT_MAX    : saturation value of the payload byte counter
//   crc32_next()    : one-byte CRC-32 update (LSB first)
package gmii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_DROP,
        ST_IFG
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
    localparam logic [10:0] BYTE_CNT_MAX  = 11'd2047;

    // Ethernet transmits each byte LSB first, so the reflected form shifts right.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                               input logic [7:0]  d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: byte-wide CRC-32 register (reflected 0xEDB88320).
//   clk   : byte clock
//   reset : synchronous, active-high; loads CRC_INIT
//   init  : reload CRC_INIT at the next edge (takes priority over en)
//   en    : fold d into the register at the next edge
//   d     : data byte
//   crc   : current register value (not inverted)
module crc32_d8
    import gmii_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  d,
    output logic [31:0] crc
);

    // NOTE: registers are written with <= so every flop samples the values that
    // existed before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc32_next(crc, d);
        end
    end

endmodule

// File: rtl/gmii_frame_tx.sv
// gmii_frame_tx: turns a valid/ready/last byte stream into complete Ethernet
// frames on an 8-bit GMII-style interface: preamble, SFD, payload, zero pad
// to MIN_PAYLOAD, CRC-32 FCS, then an inter-frame gap.
//   clk            : GMII byte clock
//   reset          : synchronous, active-high
//   s_data/s_valid/s_last/s_ready : payload stream, destination MAC first
//   gmii_txd       : registered transmit byte
//   gmii_tx_en     : registered frame valid
//   gmii_tx_er     : registered error, one cycle on an underrun abort
//   busy           : FSM not idle
//   frames_sent    : completed frames (wrapping)
//   frames_aborted : underrun aborts (wrapping)
module gmii_frame_tx
    import gmii_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 60,
    parameter int IFG_CYCLES   = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        busy,
    output logic [15:0] frames_sent,
    output logic [7:0]  frames_aborted
);

    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);
    localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);

    tx_state_e   state;
    logic [7:0]  cnt;           // shared by PRE, FCS and IFG
    logic [10:0] byte_cnt;
    logic [10:0] byte_cnt_inc;
    logic [31:0] crc;
    logic        crc_init;
    logic        crc_en;
    logic [7:0]  crc_d;
    logic [7:0]  fcs_byte;

    assign busy    = (state != ST_IDLE);
    assign s_ready = (state == ST_DATA) || (state == ST_DROP);

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        crc_init     = (state == ST_SFD);
        crc_en       = ((state == ST_DATA) && s_valid) || (state == ST_PAD);
        crc_d        = (state == ST_PAD) ? 8'h00 : s_data;
        byte_cnt_inc = (byte_cnt == BYTE_CNT_MAX) ? byte_cnt : byte_cnt + 11'd1;
        fcs_byte     = 8'h00;
        case (cnt[1:0])
            2'd0: fcs_byte = ~crc[7:0];
            2'd1: fcs_byte = ~crc[15:8];
            2'd2: fcs_byte = ~crc[23:16];
            2'd3: fcs_byte = ~crc[31:24];
            default: fcs_byte = 8'h00;
        endcase
    end

    crc32_d8 u_crc (
        .clk   (clk),
        .reset (reset),
        .init  (crc_init),
        .en    (crc_en),
        .d     (crc_d),
        .crc   (crc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= 8'd0;
            byte_cnt       <= 11'd0;
            gmii_txd       <= 8'h00;
            gmii_tx_en     <= 1'b0;
            gmii_tx_er     <= 1'b0;
            frames_sent    <= 16'd0;
            frames_aborted <= 8'd0;
        end else begin
            gmii_tx_er <= 1'b0;
            case (state)
                ST_IDLE: begin
                    gmii_txd   <= 8'h00;
                    gmii_tx_en <= 1'b0;
                    if (s_valid) begin
                        state <= ST_PRE;
                        cnt   <= 8'd0;
                    end
                end
                ST_PRE: begin
                    gmii_txd   <= PREAMBLE_BYTE;
                    gmii_tx_en <= 1'b1;
                    cnt        <= cnt + 8'd1;
                    if (cnt == PRE_LAST) state <= ST_SFD;
                end
                ST_SFD: begin
                    // Entering DATA here raises s_ready while 0xD5 is on the wire.
                    gmii_txd   <= SFD_BYTE;
                    gmii_tx_en <= 1'b1;
                    byte_cnt   <= 11'd0;
                    state      <= ST_DATA;
                end
                ST_DATA: begin
                    gmii_tx_en <= 1'b1;
                    if (s_valid) begin
                        gmii_txd <= s_data;
                        byte_cnt <= byte_cnt_inc;
                        if (s_last) begin
                            cnt   <= 8'd0;
                            state <= (byte_cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
                        end
                    end else begin
                        // Underrun: mark the frame bad on the wire and discard the rest.
                        gmii_txd       <= 8'h00;
                        gmii_tx_er     <= 1'b1;
                        frames_aborted <= frames_aborted + 8'd1;
                        state          <= ST_DROP;
                    end
                end
                ST_PAD: begin
                    gmii_txd   <= 8'h00;
                    gmii_tx_en <= 1'b1;
                    byte_cnt   <= byte_cnt_inc;
                    if (byte_cnt_inc == MIN_CNT) begin
                        cnt   <= 8'd0;
                        state <= ST_FCS;
                    end
                end
                ST_FCS: begin
                    gmii_txd   <= fcs_byte;
                    gmii_tx_en <= 1'b1;
                    cnt        <= cnt + 8'd1;
                    if (cnt[1:0] == 2'd3) begin
                        frames_sent <= frames_sent + 16'd1;
                        cnt         <= 8'd0;
                        state       <= ST_IFG;
                    end
                end
                ST_DROP: begin
                    gmii_txd   <= 8'h00;
                    gmii_tx_en <= 1'b0;
                    if (s_valid && s_last) begin
                        cnt   <= 8'd0;
                        state <= ST_IFG;
                    end
                end
                ST_IFG: begin
                    gmii_txd   <= 8'h00;
                    gmii_tx_en <= 1'b0;
                    cnt        <= cnt + 8'd1;
                    if (cnt == IFG_LAST) state <= ST_IDLE;
                end
                default: begin
                    state      <= ST_IDLE;
                    gmii_tx_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_frame_tx.sv
// tb_gmii_frame_tx: directed bench for gmii_frame_tx. A wire monitor records
// length, inter-frame gap and CRC residue of every frame seen on GMII.
module tb_gmii_frame_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        gmii_tx_er;
    logic        busy;
    logic [15:0] frames_sent;
    logic [7:0]  frames_aborted;

    gmii_frame_tx dut (
        .clk            (clk),
        .reset          (reset),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_last         (s_last),
        .s_ready        (s_ready),
        .gmii_txd       (gmii_txd),
        .gmii_tx_en     (gmii_tx_en),
        .gmii_tx_er     (gmii_tx_er),
        .busy           (busy),
        .frames_sent    (frames_sent),
        .frames_aborted (frames_aborted)
    );

    always #4 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial CRC over everything after the 8 header bytes, FCS included.
    function automatic logic [31:0] residue(input logic [7:0] b[$]);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < b.size(); i++) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    // ---------------- wire monitor (negedge sampling) ----------------
    logic [7:0]  cur[$];
    logic [7:0]  last_bytes[$];
    int          cur_len    = 0;
    int          mon_frames = 0;
    int          low_run    = 0;
    int          en_cycles  = 0;
    bit          prev_en    = 1'b0;
    int          mon_len[512];
    int          mon_gap[512];
    logic [31:0] mon_res[512];

    always @(negedge clk) begin
        if (gmii_tx_en === 1'b1) begin
            if (!prev_en) mon_gap[mon_frames % 512] = low_run;
            low_run = 0;
            cur.push_back(gmii_txd);
            cur_len++;
            en_cycles++;
        end else begin
            if (prev_en) begin
                mon_len[mon_frames % 512] = cur_len;
                mon_res[mon_frames % 512] = residue(cur);
                last_bytes = cur;
                cur.delete();
                cur_len = 0;
                mon_frames++;
            end
            low_run++;
        end
        prev_en = (gmii_tx_en === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] pl[$];

    // Call at posedge+1; returns at posedge+1 after the byte was accepted.
    task automatic push(input logic [7:0] d, input logic last);
        bit ok = 1'b0;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) check("accept_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic send_pl(input bit release_valid);
        for (int i = 0; i < pl.size(); i++) push(pl[i], i == pl.size() - 1);
        if (release_valid) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 600 && mon_frames < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (mon_frames < target) check("frame_timeout", 32'(mon_frames), 32'(target));
        @(posedge clk);
        #1;
    endtask

    function automatic int header_errs();
        int e = 0;
        if (last_bytes.size() < 8) return 99;
        for (int i = 0; i < 7; i++) if (last_bytes[i] !== 8'h55) e++;
        if (last_bytes[7] !== 8'hD5) e++;
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f0;
        int errs;
        int snap;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_txd", 32'(gmii_txd), 32'h0);
        check("rst_tx_en", 32'(gmii_tx_en), 32'h0);
        check("rst_tx_er", 32'(gmii_tx_er), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_s_ready", 32'(s_ready), 32'h0);
        check("rst_sent", 32'(frames_sent), 32'h0);
        check("rst_aborted", 32'(frames_aborted), 32'h0);
        @(posedge clk);
        #1;

        // 64-byte incrementing payload: 8 + 64 + 4 = 76 cycles of tx_en.
        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(8'(i));
        f0 = mon_frames;
        send_pl(1'b1);
        wait_frames(f0 + 1);
        check("f64_len", 32'(mon_len[f0 % 512]), 32'd76);
        check("f64_header", 32'(header_errs()), 32'd0);
        errs = 0;
        for (int i = 0; i < 64; i++) if (last_bytes[8 + i] !== 8'(i)) errs++;
        check("f64_payload", 32'(errs), 32'd0);
        check("f64_residue", mon_res[f0 % 512], 32'hDEBB_20E3);
        check("f64_sent", 32'(frames_sent), 32'd1);

        // 1-byte payload 0xAB: 59 pad bytes, 8 + 60 + 4 = 72 cycles.
        pl.delete();
        pl.push_back(8'hAB);
        f0 = mon_frames;
        send_pl(1'b1);
        wait_frames(f0 + 1);
        check("f1_len", 32'(mon_len[f0 % 512]), 32'd72);
        check("f1_byte", 32'(last_bytes[8]), 32'hAB);
        errs = 0;
        for (int i = 9; i < 68; i++) if (last_bytes[i] !== 8'h00) errs++;
        check("f1_pad", 32'(errs), 32'd0);
        check("f1_residue", mon_res[f0 % 512], 32'hDEBB_20E3);
        check("f1_sent", 32'(frames_sent), 32'd2);

        // Two 60-byte frames with s_valid held high across the boundary.
        pl.delete();
        for (int i = 0; i < 60; i++) pl.push_back(8'(i * 3 + 1));
        f0 = mon_frames;
        send_pl(1'b0);
        send_pl(1'b1);
        wait_frames(f0 + 2);
        check("b2b_len0", 32'(mon_len[f0 % 512]), 32'd72);
        check("b2b_len1", 32'(mon_len[(f0 + 1) % 512]), 32'd72);
        check("b2b_res0", mon_res[f0 % 512], 32'hDEBB_20E3);
        check("b2b_res1", mon_res[(f0 + 1) % 512], 32'hDEBB_20E3);
        check("b2b_gap", 32'(mon_gap[(f0 + 1) % 512] >= 12 && mon_gap[(f0 + 1) % 512] <= 13), 32'd1);
        check("b2b_sent", 32'(frames_sent), 32'd4);

        // Underrun after 10 payload bytes, then 5 bytes dropped.
        f0 = mon_frames;
        for (int i = 0; i < 10; i++) push(8'(i + 1), 1'b0);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        check("ur_tx_en", 32'(gmii_tx_en), 32'd1);
        check("ur_tx_er", 32'(gmii_tx_er), 32'd1);
        check("ur_txd", 32'(gmii_txd), 32'h0);
        check("ur_aborted", 32'(frames_aborted), 32'd1);
        @(negedge clk);
        #1;
        snap = en_cycles;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) push(8'(8'hC0 + i), i == 4);
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        #1;
        check("ur_drop_quiet", 32'(en_cycles - snap), 32'd0);
        check("ur_wire_len", 32'(mon_len[f0 % 512]), 32'd19);
        check("ur_sent", 32'(frames_sent), 32'd4);
        @(posedge clk);
        #1;
        pl.delete();
        for (int i = 0; i < 60; i++) pl.push_back(8'(8'hF0 - i));
        f0 = mon_frames;
        send_pl(1'b1);
        wait_frames(f0 + 1);
        check("ur_next_len", 32'(mon_len[f0 % 512]), 32'd72);
        check("ur_next_res", mon_res[f0 % 512], 32'hDEBB_20E3);
        check("ur_next_sent", 32'(frames_sent), 32'd5);

        // Reset while FCS byte 2 is on the wire.
        f0 = mon_frames;
        send_pl(1'b1);
        for (int i = 0; i < 200 && cur_len != 70; i++) begin
            @(negedge clk);
            #1;
        end
        check("rst_reach_fcs2", 32'(cur_len), 32'd70);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_tx_en", 32'(gmii_tx_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sent", 32'(frames_sent), 32'd0);
        check("mid_rst_aborted", 32'(frames_aborted), 32'd0);
        @(negedge clk);
        #1;
        check("mid_rst_cut_len", 32'(mon_len[f0 % 512]), 32'd70);
        @(posedge clk);
        #1;
        pl.delete();
        for (int i = 0; i < 20; i++) pl.push_back(8'(8'h5A ^ i));
        f0 = mon_frames;
        send_pl(1'b1);
        wait_frames(f0 + 1);
        check("post_rst_len", 32'(mon_len[f0 % 512]), 32'd72);
        check("post_rst_res", mon_res[f0 % 512], 32'hDEBB_20E3);
        check("post_rst_sent", 32'(frames_sent), 32'd1);

        // 256 aborted frames wrap frames_aborted back to zero.
        for (int i = 0; i < 256; i++) begin
            push(8'h11, 1'b0);
            s_valid = 1'b0;
            @(posedge clk);
            #1;
            push(8'h22, 1'b1);
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (i == 254) check("wrap_ff", 32'(frames_aborted), 32'hFF);
        end
        for (int i = 0; i < 100 && busy; i++) begin
            @(negedge clk);
            #1;
        end
        check("wrap_idle", 32'(busy), 32'd0);
        check("wrap_zero", 32'(frames_aborted), 32'h00);
        check("wrap_sent", 32'(frames_sent), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
